// File: rtl/watch_mode_ctrl_if.sv
// rtl/watch_mode_ctrl_if.sv - button, digit and mode/command/display bundle for watch_mode_ctrl
interface watch_mode_ctrl_if;
  logic [7:0]  btn;
  logic [27:0] dig_clk;
  logic [27:0] dig_sw;
  logic [27:0] dig_alm;
  logic [3:0]  state;
  logic [3:0]  flag;
  logic        sw_run;
  logic [6:0]  out0;
  logic [6:0]  out1;
  logic [6:0]  out2;
  logic [6:0]  out3;

  modport master (
    output btn, dig_clk, dig_sw, dig_alm,
    input  state, flag, sw_run, out0, out1, out2, out3
  );

  modport slave (
    input  btn, dig_clk, dig_sw, dig_alm,
    output state, flag, sw_run, out0, out1, out2, out3
  );
endinterface

// File: rtl/watch_mode_ctrl.sv
// rtl/watch_mode_ctrl.sv - watch button debounce, mode/command FSM and display mux
// Optional idle return to clock mode when AUTO_RETURN_EN is defined.
module watch_mode_ctrl #(
  parameter int DEB_CYCLES  = 4,
  parameter int IDLE_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  watch_mode_ctrl_if.slave   bus
);

  localparam int NB = 3;
  localparam int CW = $clog2(DEB_CYCLES);

  typedef enum logic [3:0] {
    MODE_CLK = 4'd0,
    MODE_SW  = 4'd1,
    MODE_ALM = 4'd2
  } mode_e;

  localparam logic [3:0] FLAG_HOUR  = 4'd2;
  localparam logic [3:0] FLAG_MIN   = 4'd3;
  localparam logic [3:0] FLAG_CLEAR = 4'd5;
  localparam logic [3:0] FLAG_STOP  = 4'd6;
  localparam logic [3:0] FLAG_START = 4'd7;

  logic [NB-1:0] sync1, sync2, level, level_d, evt_q;
  logic [CW-1:0] cnt [NB];
  logic          unused_btn;

  mode_e         state_q, state_n;
  logic [3:0]    flag_q, flag_n;
  logic          sw_run_q, sw_run_n;
  logic [6:0]    out_q [4];

  assign unused_btn = ^bus.btn[7:NB];

  // Events are registered once more so that decode sees a clean one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      evt_q   <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      sync1   <= bus.btn[NB-1:0];
      sync2   <= sync1;
      level_d <= level;
      evt_q   <= level & ~level_d;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
          cnt[i]   <= '0;
          level[i] <= ~level[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef AUTO_RETURN_EN
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  logic [IW-1:0] idle_q;
  logic          idle_hit;

  assign idle_hit = (idle_q == IW'(IDLE_CYCLES));

  always_ff @(posedge clk) begin
    if (rst)           idle_q <= '0;
    else if (|evt_q)   idle_q <= '0;
    else if (!idle_hit) idle_q <= idle_q + 1'b1;
  end
`else
  localparam bit unused_idle_cfg = (IDLE_CYCLES > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MODE_CLK;
      flag_q   <= '0;
      sw_run_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      flag_q   <= flag_n;
      sw_run_q <= sw_run_n;
    end
  end

  // MODE beats A, A beats B; an illegal state only ever falls back to clock mode.
  always_comb begin
    state_n  = state_q;
    flag_n   = '0;
    sw_run_n = sw_run_q;
    case (state_q)
      MODE_CLK, MODE_SW, MODE_ALM: begin
        if (evt_q[0]) begin
          case (state_q)
            MODE_CLK: state_n = MODE_SW;
            MODE_SW:  state_n = MODE_ALM;
            default:  state_n = MODE_CLK;
          endcase
        end else if (evt_q[1]) begin
          if (state_q == MODE_SW) begin
            flag_n   = sw_run_q ? FLAG_STOP : FLAG_START;
            sw_run_n = ~sw_run_q;
          end else begin
            flag_n = FLAG_HOUR;
          end
        end else if (evt_q[2]) begin
          flag_n = (state_q == MODE_SW) ? FLAG_CLEAR : FLAG_MIN;
        end
`ifdef AUTO_RETURN_EN
        else if (idle_hit && state_q != MODE_CLK && !sw_run_q) begin
          state_n = MODE_CLK;
        end
`endif
      end
      default: state_n = MODE_CLK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) out_q[i] <= '0;
    end else begin
      case (state_q)
        MODE_CLK: {out_q[0], out_q[1], out_q[2], out_q[3]} <= bus.dig_clk;
        MODE_SW:  {out_q[0], out_q[1], out_q[2], out_q[3]} <= bus.dig_sw;
        MODE_ALM: {out_q[0], out_q[1], out_q[2], out_q[3]} <= bus.dig_alm;
        default:  for (int i = 0; i < 4; i++) out_q[i] <= '0;
      endcase
    end
  end

  assign bus.state  = state_q;
  assign bus.flag   = flag_q;
  assign bus.sw_run = sw_run_q;
  assign bus.out0   = out_q[0];
  assign bus.out1   = out_q[1];
  assign bus.out2   = out_q[2];
  assign bus.out3   = out_q[3];

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// tb/tb_watch_mode_ctrl.sv - directed self-checking bench for watch_mode_ctrl
module tb_watch_mode_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic found;

  always #5 clk = ~clk;

  watch_mode_ctrl_if wif ();

  watch_mode_ctrl #(.DEB_CYCLES(4), .IDLE_CYCLES(50)) dut (
    .clk (clk),
    .rst (rst),
    .bus (wif)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input logic [6:0] e3);
    check({tag, "_out0"}, 32'(wif.out0), 32'(e0));
    check({tag, "_out1"}, 32'(wif.out1), 32'(e1));
    check({tag, "_out2"}, 32'(wif.out2), 32'(e2));
    check({tag, "_out3"}, 32'(wif.out3), 32'(e3));
  endtask

  // Press at a negedge; the flag pulse must appear only after the 8th following negedge.
  task automatic press(input int b, input logic [3:0] exp_flag, input logic [3:0] exp_state,
                       input logic exp_run, input string tag);
    wif.btn[b] = 1'b1;
    step(7);
    check({tag, "_flag_early"}, 32'(wif.flag), 32'd0);
    step(1);
    check({tag, "_flag"}, 32'(wif.flag), 32'(exp_flag));
    check({tag, "_state"}, 32'(wif.state), 32'(exp_state));
    check({tag, "_sw_run"}, 32'(wif.sw_run), 32'(exp_run));
    step(1);
    check({tag, "_flag_late"}, 32'(wif.flag), 32'd0);
    wif.btn[b] = 1'b0;
    step(10);
  endtask

  initial begin
    wif.btn     = 8'hFF;
    wif.dig_clk = 28'h0123456;
    wif.dig_sw  = 28'h1111111;
    wif.dig_alm = 28'h0000000;

    // Reset with all buttons held
    step(3);
    check("rst_state", 32'(wif.state), 32'd0);
    check("rst_flag", 32'(wif.flag), 32'd0);
    check("rst_sw_run", 32'(wif.sw_run), 32'd0);
    check_out("rst", 7'd0, 7'd0, 7'd0, 7'd0);
    rst = 1'b0;
    wif.btn = 8'h00;
    step(15);
    check("post_rst_state", 32'(wif.state), 32'd0);
    check("post_rst_flag", 32'(wif.flag), 32'd0);
    press(0, 4'd0, 4'd1, 1'b0, "repress");

    // Mid-operation reset
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst2_state", 32'(wif.state), 32'd0);
    check("rst2_flag", 32'(wif.flag), 32'd0);
    step(2);

    // Bounce on MODE
    for (int p = 0; p < 10; p++) begin
      wif.btn[0] = (p % 2 == 0);
      repeat (2) begin
        step(1);
        check("bounce_flag", 32'(wif.flag), 32'd0);
        check("bounce_state", 32'(wif.state), 32'd0);
      end
    end
    wif.btn[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step(1);
      check("bounce_hold_flag", 32'(wif.flag), 32'd0);
    end
    check("bounce_state_end", 32'(wif.state), 32'd1);
    wif.btn[0] = 1'b0;
    step(10);
    check("bounce_release_state", 32'(wif.state), 32'd1);

    // Stopwatch commands
    press(1, 4'd7, 4'd1, 1'b1, "sw_start");
    press(1, 4'd6, 4'd1, 1'b0, "sw_stop");
    press(2, 4'd5, 4'd1, 1'b0, "sw_clear");
    press(1, 4'd7, 4'd1, 1'b1, "sw_start2");

    // MODE and A rising together
    wif.btn[0] = 1'b1;
    wif.btn[1] = 1'b1;
    step(7);
    check("simul_flag_early", 32'(wif.flag), 32'd0);
    step(1);
    check("simul_state", 32'(wif.state), 32'd2);
    check("simul_flag", 32'(wif.flag), 32'd0);
    check("simul_sw_run", 32'(wif.sw_run), 32'd1);
    step(1);
    check("simul_flag_late", 32'(wif.flag), 32'd0);
    wif.btn[0] = 1'b0;
    wif.btn[1] = 1'b0;
    step(10);

    // Clock-mode commands with the stopwatch still running
    press(0, 4'd0, 4'd0, 1'b1, "to_clock");
    check_out("clk_disp", 7'd0, 7'd72, 7'd104, 7'd86);
    press(1, 4'd2, 4'd0, 1'b1, "hour_inc");
    press(2, 4'd3, 4'd0, 1'b1, "min_inc");

    // Display follows state one cycle later
    wif.btn[0] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1);
      if (wif.state == 4'd1) found = 1'b1;
    end
    check("mux_wait", 32'(found), 32'd1);
    check_out("mux_old", 7'd0, 7'd72, 7'd104, 7'd86);
    step(1);
    check_out("mux_new", 7'd8, 7'd68, 7'd34, 7'd17);
    wif.btn[0] = 1'b0;
    step(10);

    // Running stopwatch never auto-returns
    step(80);
    check("run_hold_state", 32'(wif.state), 32'd1);
    check("run_hold_sw_run", 32'(wif.sw_run), 32'd1);
    press(1, 4'd6, 4'd1, 1'b0, "sw_stop2");
    press(0, 4'd0, 4'd2, 1'b0, "to_alarm");

    step(39);
    check("idle_before", 32'(wif.state), 32'd2);
    step(1);
`ifdef AUTO_RETURN_EN
    check("idle_return", 32'(wif.state), 32'd0);
`else
    check("idle_return", 32'(wif.state), 32'd2);
`endif
    check("idle_flag", 32'(wif.flag), 32'd0);
    step(20);
`ifdef AUTO_RETURN_EN
    check("idle_after", 32'(wif.state), 32'd0);
`else
    check("idle_after", 32'(wif.state), 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
